id_ex_stage: RTL

- Pipeline stage between the register file read (ID) and the execute stage (EX) of the 5-stage pipelined CPU; this build has no branch predictor.
- Latches the register-file operands, immediate, register numbers and control bits into the ID/EX pipeline register.
- Bypasses a same-cycle writeback into the captured operands.
- Detects load-use hazards and inserts bubbles on stall or on a taken-branch flush.

---
 rtl/id_ex_stage.sv | 96 +++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with same-cycle writeback bypass,
// load-use stall detection and bubble insertion on stall or flush.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic [DW-1:0] BusA,
  input  logic [DW-1:0] BusB,
  input  logic [AW-1:0] RA,
  input  logic [AW-1:0] RB,
  input  logic [AW-1:0] RW,
  input  logic [DW-1:0] Imm,
  input  logic          UsesA,
  input  logic          UsesB,
  input  logic [5:0]    CtlIn,
  input  logic [CW-1:0] AluCtlIn,
  input  logic [AW-1:0] WbRW,
  input  logic          WbRegWr,
  input  logic [DW-1:0] WbBusW,
  input  logic          Flush,
  output logic          Stall,
  output logic [DW-1:0] ExA,
  output logic [DW-1:0] ExB,
  output logic [DW-1:0] ExImm,
  output logic [AW-1:0] ExRA,
  output logic [AW-1:0] ExRB,
  output logic [AW-1:0] ExRW,
  output logic [5:0]    ExCtl,
  output logic [CW-1:0] ExAluCtl
);

  // CtlIn/ExCtl bit order: {RegWr, MemRd, MemWr, MemToReg, ALUSrc, Branch}
  localparam int MemRdBit = 4;

  logic          wbLive;
  logic          hitA;
  logic          hitB;
  logic [DW-1:0] aNext;
  logic [DW-1:0] bNext;
  logic          depA;
  logic          depB;

  assign wbLive = WbRegWr && (WbRW != '0);
  assign hitA   = wbLive && (WbRW == RA) && (RA != '0);
  assign hitB   = wbLive && (WbRW == RB) && (RB != '0);

  // r0 reads as zero regardless of what the read bus carries
  always_comb begin
    aNext = BusA;
    bNext = BusB;
    if (RA == '0) aNext = '0;
    else if (hitA) aNext = WbBusW;
    if (RB == '0) bNext = '0;
    else if (hitB) bNext = WbBusW;
  end

  assign depA = UsesA && (RA == ExRW);
  assign depB = UsesB && (RB == ExRW);

  assign Stall = !Flush
              && ExCtl[MemRdBit]
              && (ExRW != '0)
              && (depA || depB);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ExA      <= '0;
      ExB      <= '0;
      ExImm    <= '0;
      ExRA     <= '0;
      ExRB     <= '0;
      ExRW     <= '0;
      ExCtl    <= '0;
      ExAluCtl <= '0;
    end else if (Flush) begin
      ExCtl    <= '0;
      ExAluCtl <= '0;
    end else if (Stall) begin
      ExCtl    <= '0;
      ExAluCtl <= '0;
    end else begin
      ExA      <= aNext;
      ExB      <= bNext;
      ExImm    <= Imm;
      ExRA     <= RA;
      ExRB     <= RB;
      ExRW     <= RW;
      ExCtl    <= CtlIn;
      ExAluCtl <= AluCtlIn;
    end
  end

endmodule
